// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
//   Shared definitions for the FPGA board top level: the CPU clock mode
//   encodings driven from the board switches, the clock controller FSM state
//   encoding, and the default button debounce length.
// -----------------------------------------------------------------------------
package board_pkg;

  // Board switch encoding for the CPU clock mode.
  typedef enum logic [1:0] {
    MODE_HALT  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_STEP  = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  // Clock controller FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BURST = 2'b11
  } state_e;

  // Board-clock cycles a synchronised button must be stable before it counts.
  localparam int DEB_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Push-button conditioner: 2-FF synchroniser, stability counter and
//   rising-edge detector. The accepted level changes once DEB_CYCLES
//   consecutive synchronised samples disagree with it; oRise pulses for one
//   cycle, one cycle after the accepted level goes high.
//
// Ports
//   iClk    in   board clock
//   iRst    in   synchronous active-high reset (clears all state)
//   iBtn    in   raw asynchronous button, active-high
//   oLevel  out  debounced button level
//   oRise   out  one-cycle pulse on a debounced rising edge
// -----------------------------------------------------------------------------
module btn_debounce
  import board_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iBtn,
  output logic oLevel,
  output logic oRise
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] stable_cnt;
  logic          level;
  logic          level_q;
  logic          rise;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of the others, as real flops do.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      sync       <= '0;
      stable_cnt <= '0;
      level      <= 1'b0;
      level_q    <= 1'b0;
      rise       <= 1'b0;
    end else begin
      sync    <= {sync[0], iBtn};
      level_q <= level;
      rise    <= level & ~level_q;
      // Any sample that agrees with the accepted level restarts the count,
      // so glitches shorter than DEB_CYCLES never reach the output.
      if (sync[1] == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        level      <= sync[1];
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

  assign oLevel = level;
  assign oRise  = rise;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clk_ctrl
//   CPU clock controller. Divides the board clock by DIV into a CPU clock and
//   a matching one-cycle clock enable, under HALT / RUN / single-STEP /
//   counted-BURST control from the board switches and a debounced button.
//   A started CPU cycle always completes, so oCpuClk never glitches.
//
// Ports
//   iClk       in   board clock
//   iRst       in   synchronous active-high reset
//   iMode      in   [1:0] 00 HALT, 01 RUN, 10 STEP, 11 BURST
//   iStepBtn   in   raw asynchronous push-button
//   iBurstLen  in   [15:0] CPU cycles per burst, sampled at burst launch
//   oCpuClk    out  registered divided clock (low DIV-DIV/2, high DIV/2)
//   oCpuEn     out  registered one-iClk pulse in the last phase of each cycle
//   oBusy      out  high while a CPU cycle or burst is in progress
//   oCycleCnt  out  [CNT_W-1:0] number of oCpuEn pulses, wrapping
// -----------------------------------------------------------------------------
module cpu_clk_ctrl
  import board_pkg::*;
#(
  parameter int DIV        = 10,
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int CNT_W      = 32
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [1:0]       iMode,
  input  logic             iStepBtn,
  input  logic [15:0]      iBurstLen,
  output logic             oCpuClk,
  output logic             oCpuEn,
  output logic             oBusy,
  output logic [CNT_W-1:0] oCycleCnt
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PHASE_HIGH = PW'(DIV - DIV / 2);

  mode_e       mode;
  state_e      state, state_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic [15:0] burst_cnt, burst_nxt;
  logic        last_phase;
  logic        active_nxt;
  logic        btn_rise;
  logic        unused_btn_level;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn (
    .iClk   (iClk),
    .iRst   (iRst),
    .iBtn   (iStepBtn),
    .oLevel (unused_btn_level),
    .oRise  (btn_rise)
  );

  assign mode       = mode_e'(iMode);
  assign last_phase = (phase == PHASE_LAST);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    unique case (state)
      ST_IDLE: begin
        // RUN wins over a simultaneous button edge; the edge is qualified by
        // the mode seen in the same cycle.
        if (mode == MODE_RUN) begin
          state_nxt = ST_RUN;
        end else if (btn_rise && mode == MODE_STEP) begin
          state_nxt = ST_STEP;
        end else if (btn_rise && mode == MODE_BURST && iBurstLen != '0) begin
          state_nxt = ST_BURST;
          burst_nxt = iBurstLen;
        end
      end
      ST_RUN: begin
        if (last_phase && mode != MODE_RUN) state_nxt = ST_IDLE;
      end
      ST_STEP: begin
        if (last_phase) state_nxt = ST_IDLE;
      end
      ST_BURST: begin
        if (last_phase) begin
          burst_nxt = burst_cnt - 16'd1;
          if (burst_cnt == 16'd1 || mode == MODE_HALT) begin
            state_nxt = ST_IDLE;
            burst_nxt = '0;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Phase only advances inside a CPU cycle; mode decisions are taken at the
    // last phase, so a cycle is never cut short.
    if (state == ST_IDLE || last_phase) phase_nxt = '0;
    else                                phase_nxt = phase + PW'(1);

    active_nxt = (state_nxt != ST_IDLE);
  end

  // Outputs are registered from the next state/phase so they line up with
  // the phase they describe while still coming straight from flops.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= ST_IDLE;
      phase     <= '0;
      burst_cnt <= '0;
      oCpuClk   <= 1'b0;
      oCpuEn    <= 1'b0;
      oBusy     <= 1'b0;
      oCycleCnt <= '0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      burst_cnt <= burst_nxt;
      oCpuClk   <= active_nxt && (phase_nxt >= PHASE_HIGH);
      oCpuEn    <= active_nxt && (phase_nxt == PHASE_LAST);
      oBusy     <= active_nxt;
      if (active_nxt && phase_nxt == PHASE_LAST) oCycleCnt <= oCycleCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_clk_ctrl
//   Directed bench for cpu_clk_ctrl. Main instance: DIV=10, DEB_CYCLES=4,
//   CNT_W=4 (so the sixteenth pulse wraps the counter). Second instance:
//   DIV=5 free-running in RUN for the 3-low/2-high shape and mid-cycle reset.
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_cpu_clk_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        btn;
  logic [15:0] burst_len;
  logic        cpu_clk, cpu_en, busy;
  logic [3:0]  cycle_cnt;

  logic        rst5;
  logic [1:0]  mode5;
  logic        btn5;
  logic [15:0] burst_len5;
  logic        cpu_clk5, cpu_en5, busy5;
  logic [31:0] cycle_cnt5;

  always #5 clk = ~clk;

  cpu_clk_ctrl #(.DIV(10), .DEB_CYCLES(4), .CNT_W(4)) dut (
    .iClk      (clk),
    .iRst      (rst),
    .iMode     (mode),
    .iStepBtn  (btn),
    .iBurstLen (burst_len),
    .oCpuClk   (cpu_clk),
    .oCpuEn    (cpu_en),
    .oBusy     (busy),
    .oCycleCnt (cycle_cnt)
  );

  cpu_clk_ctrl #(.DIV(5), .DEB_CYCLES(4), .CNT_W(32)) dut5 (
    .iClk      (clk),
    .iRst      (rst5),
    .iMode     (mode5),
    .iStepBtn  (btn5),
    .iBurstLen (burst_len5),
    .oCpuClk   (cpu_clk5),
    .oCpuEn    (cpu_en5),
    .oBusy     (busy5),
    .oCycleCnt (cycle_cnt5)
  );

  int checks = 0;
  int errors = 0;

  // Window statistics for the main instance, indexed by tick t (1-based).
  int t, en_cnt, first_en, last_en, min_gap, max_gap, busy_cnt, clk_hi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    t        = 0;
    en_cnt   = 0;
    first_en = -1;
    last_en  = -1;
    min_gap  = 1000;
    max_gap  = 0;
    busy_cnt = 0;
    clk_hi   = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
    if (cpu_en) begin
      en_cnt++;
      if (first_en < 0) begin
        first_en = t;
      end else begin
        if (t - last_en < min_gap) min_gap = t - last_en;
        if (t - last_en > max_gap) max_gap = t - last_en;
      end
      last_en = t;
    end
    if (busy)    busy_cnt++;
    if (cpu_clk) clk_hi++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int         clk_mism;
    int         found;
    logic [4:0] pat;

    rst = 1'b1; mode = 2'b00; btn = 1'b0; burst_len = 16'd0;
    rst5 = 1'b1; mode5 = 2'b01; btn5 = 1'b0; burst_len5 = 16'd0;
    clear_stats();
    steps(3);

    // Reset state.
    check("rst_cpu_clk", {31'b0, cpu_clk}, 0);
    check("rst_cpu_en",  {31'b0, cpu_en}, 0);
    check("rst_busy",    {31'b0, busy}, 0);
    check("rst_cnt",     {28'b0, cycle_cnt}, 0);
    check("rst5_busy",   {31'b0, busy5}, 0);

    // RUN from reset for 100 ticks: phase at tick k is (k-1) mod 10.
    rst = 1'b0; rst5 = 1'b0; mode = 2'b01;
    clear_stats();
    clk_mism = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (cpu_clk !== (((k - 1) % 10) >= 5)) clk_mism++;
    end
    check("run_en_count",   en_cnt, 10);
    check("run_first_en",   first_en, 10);
    check("run_min_gap",    min_gap, 10);
    check("run_max_gap",    max_gap, 10);
    check("run_clk_shape",  clk_mism, 0);
    check("run_clk_high",   clk_hi, 50);
    check("run_cnt",        {28'b0, cycle_cnt}, 10);

    // RUN -> HALT at phase 3: cycle completes with its pulse at phase 9.
    clear_stats();
    steps(4);
    check("halt_at_phase3_busy", {31'b0, busy}, 1);
    mode = 2'b00;
    steps(16);
    check("halt_en_count", en_cnt, 1);
    check("halt_en_tick",  first_en, 10);
    check("halt_clk_high", clk_hi, 5);
    check("halt_busy",     busy_cnt, 10);
    check("halt_cnt",      {28'b0, cycle_cnt}, 11);

    // STEP, clean press held 20 ticks: edge pulse at tick 7, state STEP from
    // tick 8, pulse at tick 17.
    mode = 2'b10;
    clear_stats();
    btn = 1'b1;
    steps(20);
    btn = 1'b0;
    steps(20);
    check("step_en_count", en_cnt, 1);
    check("step_en_tick",  first_en, 17);
    check("step_busy",     busy_cnt, 10);
    check("step_cnt",      {28'b0, cycle_cnt}, 12);

    // STEP, bouncy press: 3-tick glitches are rejected; the stable press
    // starts at tick 12.
    clear_stats();
    btn = 1'b1; steps(3);
    btn = 1'b0; steps(3);
    btn = 1'b1; steps(3);
    btn = 1'b0; steps(3);
    btn = 1'b1; steps(20);
    btn = 1'b0; steps(3);
    btn = 1'b1; steps(3);
    btn = 1'b0; steps(25);
    check("bounce_en_count", en_cnt, 1);
    check("bounce_en_tick",  first_en, 29);
    check("bounce_busy",     busy_cnt, 10);
    check("bounce_cnt",      {28'b0, cycle_cnt}, 13);

    // BURST of 3 with a second press during the burst (ignored). Sixteenth
    // pulse overall wraps the 4-bit counter.
    mode = 2'b11; burst_len = 16'd3;
    clear_stats();
    btn = 1'b1; steps(12);
    btn = 1'b0; steps(12);
    btn = 1'b1; steps(4);
    btn = 1'b0; steps(32);
    check("burst_en_count", en_cnt, 3);
    check("burst_first_en", first_en, 17);
    check("burst_last_en",  last_en, 37);
    check("burst_busy",     busy_cnt, 30);
    check("burst_cnt_wrap", {28'b0, cycle_cnt}, 0);

    // BURST with length 0: nothing happens.
    burst_len = 16'd0;
    clear_stats();
    btn = 1'b1; steps(20);
    btn = 1'b0; steps(20);
    check("burst0_en_count", en_cnt, 0);
    check("burst0_busy",     busy_cnt, 0);

    // Reset at phase 6 of the second cycle of a 5-cycle burst (tick 24).
    burst_len = 16'd5;
    clear_stats();
    btn = 1'b1; steps(12);
    btn = 1'b0; steps(12);
    check("mid_cpu_clk", {31'b0, cpu_clk}, 1);
    check("mid_busy",    {31'b0, busy}, 1);
    check("mid_cnt",     {28'b0, cycle_cnt}, 1);
    rst = 1'b1;
    step();
    check("midrst_cpu_clk", {31'b0, cpu_clk}, 0);
    check("midrst_cpu_en",  {31'b0, cpu_en}, 0);
    check("midrst_busy",    {31'b0, busy}, 0);
    check("midrst_cnt",     {28'b0, cycle_cnt}, 0);
    rst = 1'b0;
    clear_stats();
    steps(20);
    check("midrst_stays_idle", busy_cnt, 0);

    // DIV=5 instance: align on its enable, then expect 3 low / 2 high.
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      step();
      if (cpu_en5) found = 1;
    end
    check("d5_en_seen", found, 1);
    pat = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      pat[i] = cpu_clk5;
    end
    check("d5_clk_shape", {27'b0, pat}, 32'b11000);
    check("d5_en_period", {31'b0, cpu_en5}, 1);
    steps(4);
    check("d5_phase3_clk", {31'b0, cpu_clk5}, 1);
    rst5 = 1'b1;
    step();
    check("d5_rst_cpu_clk", {31'b0, cpu_clk5}, 0);
    check("d5_rst_cpu_en",  {31'b0, cpu_en5}, 0);
    check("d5_rst_busy",    {31'b0, busy5}, 0);
    check("d5_rst_cnt",     cycle_cnt5, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
